clic_irq_arbiter: RTL and testbench

// - Shares one core CLIC interrupt port between N_REQ clic_target-style requesters (e.g. M/S target and
//   per-VS-file targets). Picks the highest-ranked offer, latches it, runs the valid/ready and kill handshakes.
// - Sits between the target instances and the hart. Requesters keep their own claim logic; claim follows from req_ready_o.

---
 rtl/clic_irq_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_clic_irq_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clic_irq_arbiter.sv
// Arbitrates N_REQ CLIC target offers onto one core interrupt port: ranks, latches, handshakes, kills.
// Optional: define CLIC_ARB_ROUND_ROBIN_EN for round-robin tie-break among equal-rank offers.

module clic_irq_arbiter_rank #(
  parameter int PrioWidth = 8,
  parameter int ModeWidth = 2
) (
  input  logic [ModeWidth-1:0] mode,
  input  logic                 v,
  input  logic [PrioWidth-1:0] max,
  output logic [PrioWidth+1:0] rank
);
  logic [1:0] mrank;

  always_comb begin
    mrank = 2'd0;
    if (mode == ModeWidth'(3))      mrank = 2'd3;
    else if (mode == ModeWidth'(1)) mrank = v ? 2'd1 : 2'd2;
  end

  assign rank = {mrank, max};
endmodule

module clic_irq_arbiter #(
  parameter int N_REQ     = 2,
  parameter int SrcWidth  = 8,
  parameter int PrioWidth = 8,
  parameter int ModeWidth = 2,
  parameter int VsidWidth = 6,
  parameter int SelWidth  = $clog2(N_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_REQ-1:0]                    req_valid_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  input  logic [N_REQ-1:0][SrcWidth-1:0]      req_id_i,
  input  logic [N_REQ-1:0][PrioWidth-1:0]     req_max_i,
  input  logic [N_REQ-1:0][ModeWidth-1:0]     req_mode_i,
  input  logic [N_REQ-1:0][VsidWidth-1:0]     req_vsid_i,
  input  logic [N_REQ-1:0]                    req_v_i,
  input  logic [N_REQ-1:0]                    req_shv_i,
  input  logic [N_REQ-1:0]                    req_kill_req_i,
  output logic [N_REQ-1:0]                    req_kill_ack_o,
  output logic                                irq_valid_o,
  input  logic                                irq_ready_i,
  output logic [SrcWidth-1:0]                 irq_id_o,
  output logic [PrioWidth-1:0]                irq_max_o,
  output logic [ModeWidth-1:0]                irq_mode_o,
  output logic [VsidWidth-1:0]                irq_vsid_o,
  output logic                                irq_v_o,
  output logic                                irq_shv_o,
  output logic [SelWidth-1:0]                 irq_sel_o,
  output logic                                irq_kill_req_o,
  input  logic                                irq_kill_ack_i
);
  localparam int RankW = PrioWidth + 2;

  typedef enum logic [1:0] {IDLE, OFFER, KILL, HOLD} state_e;

  state_e                        state_q;
  logic [RankW-1:0]              lat_rank_q;
  logic                          kill_own_q;
  logic [N_REQ-1:0][RankW-1:0]   rank;
  logic [SelWidth-1:0]           win_sel;
  logic [RankW-1:0]              win_rank;
  logic                          win_any;
  logic                          preempt;
  logic                          sel_valid, sel_kill;
  logic                          handshake, kill_done;
  logic [N_REQ-1:0]              sel_onehot;

  for (genvar g = 0; g < N_REQ; g++) begin : g_rank
    clic_irq_arbiter_rank #(.PrioWidth(PrioWidth), .ModeWidth(ModeWidth)) u_rank (
      .mode (req_mode_i[g]),
      .v    (req_v_i[g]),
      .max  (req_max_i[g]),
      .rank (rank[g])
    );
  end

`ifdef CLIC_ARB_ROUND_ROBIN_EN
  logic [SelWidth-1:0] rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)          rr_ptr_q <= '0;
    else if (handshake) rr_ptr_q <= (int'(irq_sel_o) == N_REQ-1) ? '0 : irq_sel_o + 1'b1;
  end
`endif

  // Strict '>' means the first candidate visited wins a tie; visit order sets the tie-break.
  always_comb begin
    int idx;
    win_sel  = '0;
    win_rank = '0;
    win_any  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef CLIC_ARB_ROUND_ROBIN_EN
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
`else
      idx = k;
`endif
      if (req_valid_i[idx] && (!win_any || rank[idx] > win_rank)) begin
        win_any  = 1'b1;
        win_sel  = SelWidth'(idx);
        win_rank = rank[idx];
      end
    end
  end

  always_comb begin
    preempt = 1'b0;
    for (int j = 0; j < N_REQ; j++)
      if (req_valid_i[j] && SelWidth'(j) != irq_sel_o && rank[j] > lat_rank_q) preempt = 1'b1;
  end

  assign sel_valid  = req_valid_i[irq_sel_o];
  assign sel_kill   = req_kill_req_i[irq_sel_o];
  assign sel_onehot = N_REQ'(1) << irq_sel_o;
  assign handshake  = !rst_i && (state_q == OFFER || state_q == KILL) && irq_ready_i;
  assign kill_done  = !rst_i && state_q == KILL && !irq_ready_i && irq_kill_ack_i;

  assign req_ready_o    = handshake ? sel_onehot : '0;
  assign req_kill_ack_o = (kill_done && (kill_own_q || sel_kill)) ? sel_onehot : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      lat_rank_q     <= '0;
      kill_own_q     <= 1'b0;
      irq_valid_o    <= 1'b0;
      irq_kill_req_o <= 1'b0;
      irq_id_o       <= '0;
      irq_max_o      <= '0;
      irq_mode_o     <= '0;
      irq_vsid_o     <= '0;
      irq_v_o        <= 1'b0;
      irq_shv_o      <= 1'b0;
      irq_sel_o      <= '0;
    end else begin
      case (state_q)
        IDLE: if (win_any) begin
          state_q     <= OFFER;
          irq_valid_o <= 1'b1;
          kill_own_q  <= 1'b0;
          lat_rank_q  <= win_rank;
          irq_sel_o   <= win_sel;
          irq_id_o    <= req_id_i[win_sel];
          irq_max_o   <= req_max_i[win_sel];
          irq_mode_o  <= req_mode_i[win_sel];
          irq_vsid_o  <= req_vsid_i[win_sel];
          irq_v_o     <= req_v_i[win_sel];
          irq_shv_o   <= req_shv_i[win_sel];
        end
        OFFER: begin
          if (irq_ready_i) begin
            state_q     <= HOLD;
            irq_valid_o <= 1'b0;
          end else if (!sel_valid) begin
            state_q     <= IDLE;
            irq_valid_o <= 1'b0;
          end else if (sel_kill || preempt) begin
            state_q        <= KILL;
            irq_kill_req_o <= 1'b1;
            kill_own_q     <= sel_kill;
          end
        end
        KILL: begin
          if (sel_kill) kill_own_q <= 1'b1;
          if (irq_ready_i) begin
            state_q        <= HOLD;
            irq_valid_o    <= 1'b0;
            irq_kill_req_o <= 1'b0;
          end else if (irq_kill_ack_i) begin
            state_q        <= IDLE;
            irq_valid_o    <= 1'b0;
            irq_kill_req_o <= 1'b0;
          end
        end
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed bench for clic_irq_arbiter; expectations queued at stimulus, popped at observation.
module tb_clic_irq_arbiter;
  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [1:0]      req_valid_i, req_ready_o, req_v_i, req_shv_i, req_kill_req_i, req_kill_ack_o;
  logic [1:0][7:0] req_id_i, req_max_i;
  logic [1:0][1:0] req_mode_i;
  logic [1:0][5:0] req_vsid_i;
  logic            irq_valid_o, irq_ready_i, irq_v_o, irq_shv_o, irq_kill_req_o, irq_kill_ack_i;
  logic [7:0]      irq_id_o, irq_max_o;
  logic [1:0]      irq_mode_o;
  logic [5:0]      irq_vsid_o;
  logic [0:0]      irq_sel_o;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk_i = ~clk_i;

  clic_irq_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_id_i(req_id_i), .req_max_i(req_max_i), .req_mode_i(req_mode_i),
    .req_vsid_i(req_vsid_i), .req_v_i(req_v_i), .req_shv_i(req_shv_i),
    .req_kill_req_i(req_kill_req_i), .req_kill_ack_o(req_kill_ack_o),
    .irq_valid_o(irq_valid_o), .irq_ready_i(irq_ready_i),
    .irq_id_o(irq_id_o), .irq_max_o(irq_max_o), .irq_mode_o(irq_mode_o),
    .irq_vsid_o(irq_vsid_o), .irq_v_o(irq_v_o), .irq_shv_o(irq_shv_o),
    .irq_sel_o(irq_sel_o), .irq_kill_req_o(irq_kill_req_o), .irq_kill_ack_i(irq_kill_ack_i)
  );

  task automatic step(); @(posedge clk_i); #1; endtask
  task automatic settle(); #1; endtask

  task automatic expect_v(string tag, logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(logic [31:0] obs);
    string t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic set_req(int i, logic vld, logic [1:0] mode, logic v, logic [7:0] lvl, logic [7:0] id);
    req_valid_i[i] = vld;
    req_mode_i[i]  = mode;
    req_v_i[i]     = v;
    req_max_i[i]   = lvl;
    req_id_i[i]    = id;
    req_vsid_i[i]  = id[5:0];
    req_shv_i[i]   = id[0];
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0; req_kill_req_i = '0; req_v_i = '0; req_shv_i = '0;
    req_id_i = '0; req_max_i = '0; req_mode_i = '0; req_vsid_i = '0;
    irq_ready_i = 1'b0; irq_kill_ack_i = 1'b0;
    step(); step();
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!irq_valid_o && n < 10) begin step(); n++; end
    if (!irq_valid_o) begin
      errors++;
      checks++;
      $error("FAIL %s_timeout: observed irq_valid_o=0 required 1 within 10 cycles", tag);
    end
  endtask

  logic [0:0] t6_sel [4];

  initial begin
`ifdef CLIC_ARB_ROUND_ROBIN_EN
    t6_sel = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    t6_sel = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    // reset state
    do_reset();
    expect_v("rst_outputs", 0);
    chk({irq_valid_o, irq_kill_req_o, req_ready_o, req_kill_ack_o, irq_sel_o, irq_id_o, irq_mode_o});
    rst_i = 1'b0;

    // T1: M lvl 5 from req0, one-cycle latency, handshake
    set_req(0, 1, 2'd3, 0, 8'd5, 8'h11);
    step();
    expect_v("t1_offer", {1'b1, 1'b0, 8'h11, 2'd3, 8'd5});
    chk({irq_valid_o, irq_sel_o, irq_id_o, irq_mode_o, irq_max_o});
    step(); step();
    irq_ready_i = 1'b1; settle();
    expect_v("t1_ready", 2'b01);
    chk(req_ready_o);
    step();
    irq_ready_i = 1'b0; req_valid_i = '0;
    expect_v("t1_hold_valid", 0);
    chk(irq_valid_o);
    step();

    // T2: S&!v lvl 10 outranks S&v lvl 200
    set_req(0, 1, 2'd1, 1, 8'd200, 8'h20);
    set_req(1, 1, 2'd1, 0, 8'd10, 8'h21);
    step();
    expect_v("t2_offer", {1'b1, 1'b1, 2'd1, 1'b0, 8'h21, 6'h21});
    chk({irq_valid_o, irq_sel_o, irq_mode_o, irq_v_o, irq_id_o, irq_vsid_o});
    irq_ready_i = 1'b1; settle();
    expect_v("t2_ready", 2'b10);
    chk(req_ready_o);
    step();
    irq_ready_i = 1'b0; req_valid_i = '0;
    step();

    // T3: preemption by higher-rank req1, kill without requester ack
    set_req(0, 1, 2'd1, 0, 8'd3, 8'h30);
    step();
    expect_v("t3_offer0", {1'b1, 1'b0});
    chk({irq_valid_o, irq_sel_o});
    set_req(1, 1, 2'd3, 0, 8'd3, 8'h31);
    step();
    expect_v("t3_kill", {1'b1, 1'b1});
    chk({irq_valid_o, irq_kill_req_o});
    irq_kill_ack_i = 1'b1; settle();
    expect_v("t3_no_kill_ack", 2'b00);
    chk(req_kill_ack_o);
    step();
    irq_kill_ack_i = 1'b0;
    expect_v("t3_idle", {1'b0, 1'b0});
    chk({irq_valid_o, irq_kill_req_o});
    step();
    expect_v("t3_offer1", {1'b1, 1'b1, 8'h31});
    chk({irq_valid_o, irq_sel_o, irq_id_o});
    irq_ready_i = 1'b1; settle();
    expect_v("t3_ready1", 2'b10);
    chk(req_ready_o);
    step();
    irq_ready_i = 1'b0; req_valid_i = '0;
    step();

    // T4a: withdrawal drops the offer without a kill
    set_req(0, 1, 2'd1, 0, 8'd7, 8'h40);
    step();
    req_valid_i[0] = 1'b0;
    step();
    expect_v("t4_withdraw", {1'b0, 1'b0});
    chk({irq_valid_o, irq_kill_req_o});
    step();

    // T4b: requester-initiated kill is acked for one cycle
    req_valid_i[0] = 1'b1;
    step();
    req_kill_req_i[0] = 1'b1;
    step();
    expect_v("t4_kill", {1'b1, 1'b1});
    chk({irq_valid_o, irq_kill_req_o});
    irq_kill_ack_i = 1'b1; settle();
    expect_v("t4_kill_ack", 2'b01);
    chk(req_kill_ack_o);
    step();
    irq_kill_ack_i = 1'b0; req_kill_req_i = '0; req_valid_i = '0; settle();
    expect_v("t4_ack_pulse_end", {2'b00, 1'b0, 1'b0});
    chk({req_kill_ack_o, irq_valid_o, irq_kill_req_o});
    step();

    // T5: ready beats kill ack in the same cycle
    set_req(0, 1, 2'd0, 0, 8'd1, 8'h50);
    step();
    req_kill_req_i[0] = 1'b1;
    step();
    irq_ready_i = 1'b1; irq_kill_ack_i = 1'b1; settle();
    expect_v("t5_ready_wins", {2'b01, 2'b00});
    chk({req_ready_o, req_kill_ack_o});
    step();
    irq_ready_i = 1'b0; irq_kill_ack_i = 1'b0; req_kill_req_i = '0; req_valid_i = '0;
    expect_v("t5_hold", {1'b0, 1'b0});
    chk({irq_valid_o, irq_kill_req_o});
    step();

    // T6: equal-rank tie-break sequence from a fresh pointer
    do_reset();
    rst_i = 1'b0;
    set_req(0, 1, 2'd3, 0, 8'd9, 8'h60);
    set_req(1, 1, 2'd3, 0, 8'd9, 8'h61);
    for (int h = 0; h < 4; h++) begin
      expect_v($sformatf("t6_sel%0d", h), {31'd0, t6_sel[h]});
      wait_valid("t6");
      chk({31'd0, irq_sel_o});
      expect_v($sformatf("t6_ready%0d", h), {30'd0, 2'b01 << t6_sel[h]});
      irq_ready_i = 1'b1; settle();
      chk({30'd0, req_ready_o});
      step();
      irq_ready_i = 1'b0;
    end

    // reset in the middle of an offer
    wait_valid("t6_rst");
    rst_i = 1'b1; irq_ready_i = 1'b1; settle();
    expect_v("rst_gates_ready", 2'b00);
    chk(req_ready_o);
    step();
    expect_v("rst_mid_offer", 0);
    chk({irq_valid_o, irq_kill_req_o, req_ready_o, req_kill_ack_o, irq_sel_o, irq_id_o});
    rst_i = 1'b0; irq_ready_i = 1'b0; req_valid_i = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
